// File: rtl/blake2_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// blake2_ctrl_pkg
//   Shared definitions for the BLAKE2 front-end control blocks
//   (controller_fifo_stack and blake2_msg_assembler).
//   - default parameter constants (FIFO word width, packet/block geometry,
//     message counter width)
//   - assembler state enum
//   - packet/block width derivation helpers
// ---------------------------------------------------------------------------
package blake2_ctrl_pkg;

   localparam int DEF_DBITS    = 2;   // FIFO word width
   localparam int DEF_RD_PKT   = 2;   // words per FIFO read packet
   localparam int DEF_BLK_PKTS = 4;   // packets per message block
   localparam int DEF_CBITS    = 16;  // message word counter width

   typedef enum logic [1:0] {
      FILL = 2'd0,   // collecting packets from the FIFO
      HOLD = 2'd1,   // block full, waiting to learn whether more data follows
      SEND = 2'd2    // block presented to the compression core
   } asm_state_e;

   // packet width in bits
   function automatic int pkt_width(input int dbits, input int rd_pkt);
      return dbits * rd_pkt;
   endfunction

   // block width in bits
   function automatic int blk_width(input int dbits, input int rd_pkt, input int blk_pkts);
      return dbits * rd_pkt * blk_pkts;
   endfunction

endpackage

// File: rtl/msg_pkt_buffer.sv
// ---------------------------------------------------------------------------
// msg_pkt_buffer
//   Block staging buffer: NSLOT packet slots of PW bits, written one slot at
//   a time by index, cleared synchronously, presented as one flat word with
//   slot k at bits [(k+1)*PW-1 : k*PW].
// Ports:
//   clk      in   clock
//   reset_n  in   asynchronous active-low reset (clears all slots)
//   wr_en    in   write wr_data into slot wr_idx
//   wr_idx   in   [IW]  slot index
//   wr_data  in   [PW]  packet
//   clr      in   synchronous clear of all slots (wins over wr_en)
//   data     out  [NSLOT*PW] packed block
// ---------------------------------------------------------------------------
module msg_pkt_buffer #(
   parameter int PW    = 4,
   parameter int NSLOT = 4,
   parameter int IW    = 3
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  wr_en,
   input  logic [IW-1:0]         wr_idx,
   input  logic [PW-1:0]         wr_data,
   input  logic                  clr,
   output logic [NSLOT*PW-1:0]   data
);

   logic [NSLOT-1:0][PW-1:0] slot;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         slot <= '0;
      end else if (clr) begin
         slot <= '0;
      end else if (wr_en) begin
         for (int k = 0; k < NSLOT; k++)
            if (wr_idx == IW'(k)) slot[k] <= wr_data;
      end
   end

   assign data = slot;

endmodule

// File: rtl/blake2_msg_assembler.sv
// ---------------------------------------------------------------------------
// blake2_msg_assembler
//   Pops packets from controller_fifo_stack and packs them into message
//   blocks for the BLAKE2 compression core. Tracks the running message word
//   count t and the final-block flag. A full block is held back until either
//   more FIFO data shows up (non-final) or end of message is known (final),
//   so no block is mis-flagged and no empty trailing block is emitted.
// Ports:
//   clk         in   clock
//   reset_n     in   asynchronous active-low reset
//   fifo_empty  in   FIFO empty flag
//   fifo_dout   in   [PW] FIFO packet, valid the cycle after fifo_rd
//   fifo_rd     out  FIFO pop request (only when fifo_empty=0)
//   msg_end     in   end-of-message pulse, latched internally
//   blk_valid   out  block available
//   blk_ready   in   core accepts block
//   blk_data    out  [BW] packed block, packet k at [(k+1)*PW-1 : k*PW]
//   blk_t       out  [cbits] message words up to and including this block
//   blk_final   out  last block of the message
//   blk_num     out  [8] block index within message (ASM_BLKCNT_EN only)
// Optional build macro: ASM_BLKCNT_EN adds the blk_num port and counter.
// ---------------------------------------------------------------------------
module blake2_msg_assembler
   import blake2_ctrl_pkg::*;
#(
   parameter int  dbits    = DEF_DBITS,
   parameter int  rd_pkt   = DEF_RD_PKT,
   parameter int  blk_pkts = DEF_BLK_PKTS,
   parameter int  cbits    = DEF_CBITS,
   localparam int PW       = pkt_width(dbits, rd_pkt),
   localparam int BW       = blk_width(dbits, rd_pkt, blk_pkts)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             fifo_empty,
   input  logic [PW-1:0]    fifo_dout,
   output logic             fifo_rd,
   input  logic             msg_end,
   output logic             blk_valid,
   input  logic             blk_ready,
   output logic [BW-1:0]    blk_data,
   output logic [cbits-1:0] blk_t,
   output logic             blk_final
`ifdef ASM_BLKCNT_EN
   ,
   output logic [7:0]       blk_num
`endif
);

   localparam int CW = $clog2(blk_pkts + 1);

   asm_state_e       state;
   logic [CW-1:0]    pkt_cnt;
   logic             rd_pend;
   logic             end_req;
   logic [cbits-1:0] t;

   logic             full;
   logic             can_final;
   logic             hs;
   logic [cbits-1:0] t_next;

   assign full      = (32'(pkt_cnt) == blk_pkts);
   // an empty final block is only legitimate for an empty message
   assign can_final = (pkt_cnt != '0) || (t == '0);
   assign hs        = (state == SEND) && blk_ready;
   assign t_next    = t + cbits'(32'(pkt_cnt) * rd_pkt);

   // Counting the in-flight read keeps back-to-back pops from overfilling.
   // Gated by reset_n so the pop request is low while reset is held.
   assign fifo_rd = reset_n && (state == FILL) && !fifo_empty &&
                    ((32'(pkt_cnt) + 32'(rd_pend)) < blk_pkts);

   msg_pkt_buffer #(.PW(PW), .NSLOT(blk_pkts), .IW(CW)) u_buf (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   ((state == FILL) && rd_pend),
      .wr_idx  (pkt_cnt),
      .wr_data (fifo_dout),
      .clr     (hs),
      .data    (blk_data)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= FILL;
         pkt_cnt   <= '0;
         rd_pend   <= 1'b0;
         end_req   <= 1'b0;
         t         <= '0;
         blk_valid <= 1'b0;
         blk_t     <= '0;
         blk_final <= 1'b0;
`ifdef ASM_BLKCNT_EN
         blk_num   <= '0;
`endif
      end else begin
         if (msg_end) end_req <= 1'b1;
         case (state)
            FILL: begin
               rd_pend <= fifo_rd;
               if (rd_pend) pkt_cnt <= pkt_cnt + CW'(1);
               // transitions wait for the in-flight packet to land
               if (!rd_pend && full) begin
                  state <= HOLD;
               end else if (!rd_pend && end_req && fifo_empty && can_final) begin
                  state     <= SEND;
                  blk_valid <= 1'b1;
                  blk_final <= 1'b1;
                  blk_t     <= t_next;
                  t         <= t_next;
               end
            end
            HOLD: begin
               // pending data proves this block is not the last one
               if (!fifo_empty || end_req) begin
                  state     <= SEND;
                  blk_valid <= 1'b1;
                  blk_final <= fifo_empty;
                  blk_t     <= t_next;
                  t         <= t_next;
               end
            end
            SEND: begin
               if (blk_ready) begin
                  state     <= FILL;
                  blk_valid <= 1'b0;
                  pkt_cnt   <= '0;
                  if (blk_final) begin
                     t       <= '0;
                     // a pulse in this very cycle belongs to the next message
                     end_req <= msg_end;
                  end
`ifdef ASM_BLKCNT_EN
                  blk_num <= blk_final ? 8'd0 : blk_num + 8'd1;
`endif
               end
            end
            default: state <= FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_blake2_msg_assembler.sv
// ---------------------------------------------------------------------------
// tb_blake2_msg_assembler
//   Directed bench for blake2_msg_assembler with default geometry
//   (PW=4, BW=16, cbits=16). A small array FIFO with 1-cycle read latency
//   feeds the DUT. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_blake2_msg_assembler;

   localparam int PW = 4;
   localparam int BW = 16;
   localparam int CB = 16;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          fifo_empty;
   logic [PW-1:0] fifo_dout;
   logic          fifo_rd;
   logic          msg_end = 1'b0;
   logic          blk_valid;
   logic          blk_ready = 1'b1;
   logic [BW-1:0] blk_data;
   logic [CB-1:0] blk_t;
   logic          blk_final;
`ifdef ASM_BLKCNT_EN
   logic [7:0]    blk_num;
`endif

   int total = 0;
   int bad   = 0;

   blake2_msg_assembler dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .fifo_empty (fifo_empty),
      .fifo_dout  (fifo_dout),
      .fifo_rd    (fifo_rd),
      .msg_end    (msg_end),
      .blk_valid  (blk_valid),
      .blk_ready  (blk_ready),
      .blk_data   (blk_data),
      .blk_t      (blk_t),
      .blk_final  (blk_final)
`ifdef ASM_BLKCNT_EN
      ,
      .blk_num    (blk_num)
`endif
   );

   always #5 clk = ~clk;

   // FIFO model: writes from the stimulus, 1-cycle latency pops from the DUT
   logic [PW-1:0] mem [0:63];
   int wr_ptr = 0;
   int rd_ptr = 0;
   assign fifo_empty = (wr_ptr == rd_ptr);

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr    <= wr_ptr;
         fifo_dout <= '0;
      end else if (fifo_rd) begin
         fifo_dout <= mem[rd_ptr];
         rd_ptr    <= rd_ptr + 1;
      end
   end

   task automatic push(input logic [PW-1:0] v);
      mem[wr_ptr] = v;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_end();
      msg_end = 1'b1;
      step(1);
      msg_end = 1'b0;
   endtask

   task automatic wait_valid(input string tag, input int budget);
      int n;
      n = 0;
      while (!blk_valid && n < budget) begin
         step(1);
         n++;
      end
      total++;
      if (!blk_valid) begin
         bad++;
         $error("FAIL %s timeout observed=blk_valid 0 expected=blk_valid 1 within %0d cycles", tag, budget);
      end
   endtask

   initial begin
      int seen;

      // ---- reset state
      step(2);
      check("rst_fifo_rd", 32'(fifo_rd), 32'h0);
      check("rst_valid", 32'(blk_valid), 32'h0);
      check("rst_data", 32'(blk_data), 32'h0);
      check("rst_t", 32'(blk_t), 32'h0);
      check("rst_final", 32'(blk_final), 32'h0);
      reset_n = 1'b1;
      step(2);

      // ---- 1: reset mid-FILL with two packets stored
      push(4'h9);
      push(4'h6);
      step(6);
      check("t1_partial_data", 32'(blk_data), 32'h0069);
      check("t1_partial_valid", 32'(blk_valid), 32'h0);
      reset_n = 1'b0;
      step(1);
      reset_n = 1'b1;
      check("t1_fifo_rd", 32'(fifo_rd), 32'h0);
      check("t1_valid", 32'(blk_valid), 32'h0);
      check("t1_data", 32'(blk_data), 32'h0);
      check("t1_t", 32'(blk_t), 32'h0);
      check("t1_final", 32'(blk_final), 32'h0);
      step(4);
      check("t1_idle_valid", 32'(blk_valid), 32'h0);
      check("t1_idle_data", 32'(blk_data), 32'h0);

      // ---- 2: full block held until more data arrives
      push(4'h1); push(4'h2); push(4'h3); push(4'h4);
      step(10);
      check("t2_hold_valid", 32'(blk_valid), 32'h0);
      check("t2_hold_data", 32'(blk_data), 32'h4321);
      push(4'h5);
      check("t2_hold_no_rd", 32'(fifo_rd), 32'h0);
      wait_valid("t2_send", 5);
      check("t2_data", 32'(blk_data), 32'h4321);
      check("t2_t", 32'(blk_t), 32'd8);
      check("t2_final", 32'(blk_final), 32'h0);
`ifdef ASM_BLKCNT_EN
      check("t2_num", 32'(blk_num), 32'd0);
`endif
      step(1);
      check("t2_valid_drop", 32'(blk_valid), 32'h0);
      step(6);
      check("t2_next_data", 32'(blk_data), 32'h0005);
      pulse_end();
      wait_valid("t2_tail", 10);
      check("t2_tail_data", 32'(blk_data), 32'h0005);
      check("t2_tail_t", 32'(blk_t), 32'd10);
      check("t2_tail_final", 32'(blk_final), 32'h1);
`ifdef ASM_BLKCNT_EN
      check("t2_tail_num", 32'(blk_num), 32'd1);
`endif
      step(1);

      // ---- 3: exact full block then end of message
      push(4'hA); push(4'hB); push(4'hC); push(4'hD);
      step(8);
      check("t3_hold_valid", 32'(blk_valid), 32'h0);
      pulse_end();
      wait_valid("t3_send", 10);
      check("t3_data", 32'(blk_data), 32'hDCBA);
      check("t3_t", 32'(blk_t), 32'd8);
      check("t3_final", 32'(blk_final), 32'h1);
      step(1);
      check("t3_valid_drop", 32'(blk_valid), 32'h0);

      // ---- 4: partial final block, zero padded (t restarted from 0)
      push(4'h3); push(4'h7);
      step(6);
      pulse_end();
      wait_valid("t4_send", 10);
      check("t4_data", 32'(blk_data), 32'h0073);
      check("t4_t", 32'(blk_t), 32'd4);
      check("t4_final", 32'(blk_final), 32'h1);
      step(1);

      // ---- 5: empty message
      step(2);
      pulse_end();
      wait_valid("t5_send", 10);
      check("t5_data", 32'(blk_data), 32'h0);
      check("t5_t", 32'(blk_t), 32'h0);
      check("t5_final", 32'(blk_final), 32'h1);
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         step(1);
         if (blk_valid) seen++;
      end
      check("t5_single_hs", 32'(seen), 32'd0);

      // ---- 6: back-pressure while FIFO fills
      blk_ready = 1'b0;
      push(4'h1); push(4'h2); push(4'h3); push(4'h4);
      step(10);
      push(4'h5); push(4'h6); push(4'h7); push(4'h8);
      wait_valid("t6_send", 5);
      for (int i = 0; i < 5; i++) begin
         check("t6_stall_fifo_rd", 32'(fifo_rd), 32'h0);
         check("t6_stall_valid", 32'(blk_valid), 32'h1);
         check("t6_stall_data", 32'(blk_data), 32'h4321);
         check("t6_stall_t", 32'(blk_t), 32'd8);
         check("t6_stall_final", 32'(blk_final), 32'h0);
         step(1);
      end
      blk_ready = 1'b1;
      step(1);
      check("t6_one_xfer", 32'(blk_valid), 32'h0);
      step(10);
      check("t6_next_hold_valid", 32'(blk_valid), 32'h0);
      check("t6_next_data", 32'(blk_data), 32'h8765);
      pulse_end();
      wait_valid("t6_tail", 10);
      check("t6_tail_data", 32'(blk_data), 32'h8765);
      check("t6_tail_t", 32'(blk_t), 32'd16);
      check("t6_tail_final", 32'(blk_final), 32'h1);
`ifdef ASM_BLKCNT_EN
      check("t6_tail_num", 32'(blk_num), 32'd1);
`endif
      step(1);
      check("t6_tail_drop", 32'(blk_valid), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=no finish expected=finish within 200000 time units");
      $fatal(1, "watchdog");
   end

endmodule
